store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the clock and reset is the synchronous active-high reset.
REQ-002 Parameter WIDTH, default 32, SHALL set the address and data width.
REQ-003 Parameter NUM_EXP, default 1, range 1..16, SHALL set the number of expected stores.
REQ-004 Parameter EXP_ADR, default 100, SHALL be a packed NUM_EXP*WIDTH vector; entry i occupies bits [i*WIDTH +: WIDTH].
REQ-005 Parameter EXP_DATA, default 7, SHALL be a packed NUM_EXP*WIDTH vector of expected store data, laid out the same way.
REQ-006 Parameter ORDERED, default 1, SHALL select the match mode: 1 = stores must occur in index order; 0 = any order, each entry matched once.
REQ-007 Parameters IGN_BASE (default 96) and IGN_MASK (default all ones) SHALL define the tolerated-store window: (DataAdr & IGN_MASK) == IGN_BASE.
REQ-008 Parameter TIMEOUT_CYC, default 1000, SHALL set the cycle limit in RUN; 0 disables the timeout.
REQ-009 Ports SHALL be as follows, one per line:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- MemWrite  in  1  store strobe
- DataAdr  in  WIDTH  store address
- WriteData  in  WIDTH  store data
- done  out  1  terminal state reached
- pass  out  1  all expected stores matched
- fail  out  1  unexpected store seen
- timeout  out  1  cycle limit expired
- match_count  out  5  number of entries matched
- err_adr  out  WIDTH  address of the offending store
- err_data  out  WIDTH  data of the offending store

Function
REQ-010 The FSM SHALL have states RUN, PASS, FAIL and TIMEOUT; reset SHALL force RUN.
REQ-011 The inputs SHALL be sampled on each rising clk edge; a store is a cycle in which MemWrite == 1 and the FSM is in RUN.
REQ-012 Classification of a store SHALL follow this precedence: expected match first, then tolerated window, otherwise unexpected.
REQ-013 In ORDERED=1 mode, a store SHALL be an expected match only if DataAdr == EXP_ADR[match_count] and WriteData == EXP_DATA[match_count].
REQ-014 In ORDERED=0 mode, a store SHALL be an expected match if it matches any entry whose hit bit is clear; the lowest such index SHALL have its hit bit set.
REQ-015 A store that equals an already-hit entry and lies outside the window SHALL be treated as unexpected.
REQ-016 An expected match SHALL increment match_count by exactly 1.
REQ-017 When match_count reaches NUM_EXP, the FSM SHALL enter PASS on that same edge, so pass is visible 1 cycle after the final store.
REQ-018 A tolerated store SHALL change no state, counter or output.
REQ-019 An unexpected store SHALL move the FSM to FAIL and capture DataAdr into err_adr and WriteData into err_data on the same edge.
REQ-020 The cycle counter SHALL increment every cycle in RUN and saturate; when TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC-1 in RUN, the next state SHALL be TIMEOUT.
REQ-021 If the final expected match and timeout expiry occur on the same edge, PASS SHALL win.
REQ-022 PASS, FAIL and TIMEOUT SHALL be sticky until reset; MemWrite SHALL be ignored in those states.
REQ-023 done SHALL equal pass | fail | timeout, and at most one of pass, fail and timeout SHALL be 1 at any time.
REQ-024 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-025 While reset == 1, the FSM SHALL be in RUN and all outputs, the cycle counter and the hit bits SHALL be 0.
REQ-026 Reset asserted mid-run or in a terminal state SHALL clear everything on the next edge, and checking SHALL restart from entry 0.
REQ-027 A store present in a cycle where reset == 1 SHALL be ignored.

Verification
REQ-028 Defaults: stores (96,3), (96,5), (100,7) -> pass = 1 one cycle after the (100,7) store, match_count = 1, fail = 0.
REQ-029 Defaults: store (104,7) -> fail = 1 next cycle, err_adr = 104, err_data = 7; a later store (100,7) -> pass stays 0.
REQ-030 NUM_EXP = 2, ORDERED = 1, entries (100,7), (104,9): stores (104,9) then (100,7) -> fail with err_adr = 104.
REQ-031 Same entries with ORDERED = 0: stores (104,9), (100,7) -> pass, match_count = 2; a duplicate (104,9) before completion -> fail.
REQ-032 TIMEOUT_CYC = 10 with no stores -> timeout = 1 after 10 RUN cycles; with the final match on cycle 10 -> pass = 1 and timeout = 0.
REQ-033 Reset asserted for 1 cycle after pass -> all outputs 0, then stores (96,1), (100,7) -> pass again.

Source files
------------

// File: rtl/store_checker.sv
// Watches a processor's store bus and decides whether the expected stores happened.
// Stores in the tolerated address window are ignored. The result latches until reset.
module store_checker #(
  parameter int                         WIDTH       = 32,
  parameter int                         NUM_EXP     = 1,
  parameter logic [NUM_EXP*WIDTH-1:0]   EXP_ADR     = 100,
  parameter logic [NUM_EXP*WIDTH-1:0]   EXP_DATA    = 7,
  parameter bit                         ORDERED     = 1'b1,
  parameter logic [WIDTH-1:0]           IGN_BASE    = 96,
  parameter logic [WIDTH-1:0]           IGN_MASK    = '1,
  parameter int                         TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [4:0]       match_count,
  output logic [WIDTH-1:0] err_adr,
  output logic [WIDTH-1:0] err_data
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [31:0] TO_LIM = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
  localparam logic [4:0]  N_EXP  = 5'(NUM_EXP);

  state_t             state_q;
  logic [31:0]        cyc_q;
  logic [NUM_EXP-1:0] hit_q;
  logic [4:0]         match_count_q;
  logic               done_q, pass_q, fail_q, timeout_q;
  logic [WIDTH-1:0]   err_adr_q, err_data_q;

  logic [NUM_EXP-1:0] eq;
  logic [NUM_EXP-1:0] avail;
  logic [NUM_EXP-1:0] first;
  logic               ord_hit;
  logic               exp_match;
  logic               tolerated;
  logic [4:0]         match_count_d;
  logic               last_match;
  logic               to_hit;

  // One address/data comparator per expected entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_EXP; gi++) begin : g_eq
      assign eq[gi] = (DataAdr   == EXP_ADR[gi*WIDTH +: WIDTH]) &&
                      (WriteData == EXP_DATA[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  always_comb begin
    ord_hit = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (match_count_q == 5'(i)) ord_hit = eq[i];
    end
    // Unmatched entries only; isolate the lowest set bit with x & -x.
    avail         = eq & ~hit_q;
    first         = avail & (~avail + NUM_EXP'(1));
    exp_match     = ORDERED ? ord_hit : (|avail);
    tolerated     = ((DataAdr & IGN_MASK) == IGN_BASE);
    match_count_d = match_count_q + 5'd1;
    last_match    = (match_count_d == N_EXP);
    to_hit        = (TIMEOUT_CYC != 0) && (cyc_q == TO_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      cyc_q         <= '0;
      hit_q         <= '0;
      match_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_adr_q     <= '0;
      err_data_q    <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          cyc_q <= (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
          if (MemWrite && exp_match) begin
            match_count_q <= match_count_d;
            if (!ORDERED) hit_q <= hit_q | first;
            // A final match on the expiry edge still counts as a pass.
            if (last_match) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
            end else if (to_hit) begin
              state_q   <= S_TIMEOUT;
              timeout_q <= 1'b1;
              done_q    <= 1'b1;
            end
          end else if (MemWrite && !tolerated) begin
            state_q    <= S_FAIL;
            fail_q     <= 1'b1;
            done_q     <= 1'b1;
            err_adr_q  <= DataAdr;
            err_data_q <= WriteData;
          end else if (to_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign match_count = match_count_q;
  assign err_adr     = err_adr_q;
  assign err_data    = err_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: four parameterisations share one stimulus bus
// and each scenario resets all of them before checking the instance it targets.
module tb_store_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mw = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;

  logic [3:0]  done_w, pass_w, fail_w, to_w;
  logic [4:0]  mc_w [4];
  logic [31:0] ea_w [4];
  logic [31:0] ed_w [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: two entries ordered, 2: two entries any order, 3: timeout 10
  store_checker u0 (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(to_w[0]),
    .match_count(mc_w[0]), .err_adr(ea_w[0]), .err_data(ed_w[0]));

  store_checker #(.NUM_EXP(2), .ORDERED(1'b1),
                  .EXP_ADR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7})) u1 (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(to_w[1]),
    .match_count(mc_w[1]), .err_adr(ea_w[1]), .err_data(ed_w[1]));

  store_checker #(.NUM_EXP(2), .ORDERED(1'b0),
                  .EXP_ADR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7})) u2 (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .timeout(to_w[2]),
    .match_count(mc_w[2]), .err_adr(ea_w[2]), .err_data(ed_w[2]));

  store_checker #(.TIMEOUT_CYC(10)) u3 (
    .clk(clk), .reset(reset), .MemWrite(mw), .DataAdr(adr), .WriteData(dat),
    .done(done_w[3]), .pass(pass_w[3]), .fail(fail_w[3]), .timeout(to_w[3]),
    .match_count(mc_w[3]), .err_adr(ea_w[3]), .err_data(ed_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Called at a negedge; returns at a negedge with outputs reflecting the reset.
  task automatic rst();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; store is sampled by the next posedge, returns at the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mw = 1'b1; adr = a; dat = d;
    @(negedge clk);
    mw = 1'b0; adr = '0; dat = '0;
  endtask

  initial begin
    @(negedge clk);

    // Reset with a matching store present: the store must be ignored.
    reset = 1'b1; mw = 1'b1; adr = 32'd100; dat = 32'd7;
    @(negedge clk);
    reset = 1'b0; mw = 1'b0; adr = '0; dat = '0;
    check("rst_done",    32'(done_w[0]), 0);
    check("rst_pass",    32'(pass_w[0]), 0);
    check("rst_fail",    32'(fail_w[0]), 0);
    check("rst_timeout", 32'(to_w[0]), 0);
    check("rst_mc",      32'(mc_w[0]), 0);
    check("rst_erradr",  ea_w[0], 0);

    // Defaults: tolerated stores then the expected one.
    store(32'd96, 32'd3);
    check("tol1_pass", 32'(pass_w[0]), 0);
    check("tol1_fail", 32'(fail_w[0]), 0);
    store(32'd96, 32'd5);
    check("tol2_mc", 32'(mc_w[0]), 0);
    store(32'd100, 32'd7);
    check("def_pass", 32'(pass_w[0]), 1);
    check("def_mc",   32'(mc_w[0]), 1);
    check("def_fail", 32'(fail_w[0]), 0);
    check("def_done", 32'(done_w[0]), 1);
    store(32'd104, 32'd7);
    check("sticky_pass", 32'(pass_w[0]), 1);
    check("sticky_fail", 32'(fail_w[0]), 0);

    // Reset after pass, then a fresh run.
    rst();
    check("rerst_pass", 32'(pass_w[0]), 0);
    check("rerst_done", 32'(done_w[0]), 0);
    check("rerst_mc",   32'(mc_w[0]), 0);
    store(32'd96, 32'd1);
    store(32'd100, 32'd7);
    check("rerun_pass", 32'(pass_w[0]), 1);

    // Defaults: unexpected store.
    rst();
    store(32'd104, 32'd7);
    check("unexp_fail",   32'(fail_w[0]), 1);
    check("unexp_erradr", ea_w[0], 104);
    check("unexp_errdat", ed_w[0], 7);
    check("unexp_pass",   32'(pass_w[0]), 0);
    store(32'd100, 32'd7);
    check("after_fail_pass", 32'(pass_w[0]), 0);
    check("after_fail_fail", 32'(fail_w[0]), 1);

    // Ordered, wrong order.
    rst();
    store(32'd104, 32'd9);
    check("ord_bad_fail",   32'(fail_w[1]), 1);
    check("ord_bad_erradr", ea_w[1], 104);
    // Ordered, right order.
    rst();
    store(32'd100, 32'd7);
    check("ord_mc1",   32'(mc_w[1]), 1);
    check("ord_pass0", 32'(pass_w[1]), 0);
    store(32'd104, 32'd9);
    check("ord_pass", 32'(pass_w[1]), 1);
    check("ord_mc2",  32'(mc_w[1]), 2);

    // Unordered, reversed order passes.
    rst();
    store(32'd104, 32'd9);
    check("any_mc1", 32'(mc_w[2]), 1);
    store(32'd100, 32'd7);
    check("any_pass", 32'(pass_w[2]), 1);
    check("any_mc2",  32'(mc_w[2]), 2);
    // Unordered, duplicate fails.
    rst();
    store(32'd104, 32'd9);
    store(32'd104, 32'd9);
    check("dup_fail",   32'(fail_w[2]), 1);
    check("dup_errdat", ed_w[2], 9);
    check("dup_mc",     32'(mc_w[2]), 1);

    // Timeout after 10 RUN cycles.
    rst();
    repeat (9) @(negedge clk);
    check("to_early", 32'(to_w[3]), 0);
    @(negedge clk);
    check("to_hit",  32'(to_w[3]), 1);
    check("to_done", 32'(done_w[3]), 1);
    check("to_pass", 32'(pass_w[3]), 0);

    // Final match on cycle 10: pass wins.
    rst();
    repeat (9) @(negedge clk);
    store(32'd100, 32'd7);
    check("race_pass",    32'(pass_w[3]), 1);
    check("race_timeout", 32'(to_w[3]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
